// File: rtl/dezigzag_buffer.sv
// dezigzag_buffer
//   Two-bank (ping-pong) reorder buffer. Coefficients arrive in JPEG zigzag
//   order and leave in raster order (r = 8*row + col). Each incoming
//   coefficient is written straight to its raster slot, so the read side is a
//   plain linear scan of a full bank.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data holds a coefficient
//   in_ready   : write bank has room (bank not full)
//   in_data    : signed coefficient, zigzag order k = 0..63
//   out_valid  : read bank holds a complete block
//   out_ready  : downstream accepts out_data
//   out_data   : signed coefficient, raster order
//   out_index  : raster index of out_data
//   out_last   : high with out_index == 63
module dezigzag_buffer #(
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [5:0]               out_index,
  output logic                     out_last
);

  // Bank b occupies mem[{b, raster}]; contents are never reset.
  logic signed [DATA_W-1:0] mem [0:127];

  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       wr_bank;
  logic       rd_bank;
  logic [5:0] wcnt;
  logic [5:0] rcnt;
  logic       wr_fire;
  logic       rd_fire;
  logic       wr_done;
  logic       rd_done;

  // Zigzag position -> raster index.
  function automatic logic [5:0] zz(input logic [5:0] k);
    case (k)
      6'd0:  return 6'd0;   6'd1:  return 6'd1;   6'd2:  return 6'd8;   6'd3:  return 6'd16;
      6'd4:  return 6'd9;   6'd5:  return 6'd2;   6'd6:  return 6'd3;   6'd7:  return 6'd10;
      6'd8:  return 6'd17;  6'd9:  return 6'd24;  6'd10: return 6'd32;  6'd11: return 6'd25;
      6'd12: return 6'd18;  6'd13: return 6'd11;  6'd14: return 6'd4;   6'd15: return 6'd5;
      6'd16: return 6'd12;  6'd17: return 6'd19;  6'd18: return 6'd26;  6'd19: return 6'd33;
      6'd20: return 6'd40;  6'd21: return 6'd48;  6'd22: return 6'd41;  6'd23: return 6'd34;
      6'd24: return 6'd27;  6'd25: return 6'd20;  6'd26: return 6'd13;  6'd27: return 6'd6;
      6'd28: return 6'd7;   6'd29: return 6'd14;  6'd30: return 6'd21;  6'd31: return 6'd28;
      6'd32: return 6'd35;  6'd33: return 6'd42;  6'd34: return 6'd49;  6'd35: return 6'd56;
      6'd36: return 6'd57;  6'd37: return 6'd50;  6'd38: return 6'd43;  6'd39: return 6'd36;
      6'd40: return 6'd29;  6'd41: return 6'd22;  6'd42: return 6'd15;  6'd43: return 6'd23;
      6'd44: return 6'd30;  6'd45: return 6'd37;  6'd46: return 6'd44;  6'd47: return 6'd51;
      6'd48: return 6'd58;  6'd49: return 6'd59;  6'd50: return 6'd52;  6'd51: return 6'd45;
      6'd52: return 6'd38;  6'd53: return 6'd31;  6'd54: return 6'd39;  6'd55: return 6'd46;
      6'd56: return 6'd53;  6'd57: return 6'd60;  6'd58: return 6'd61;  6'd59: return 6'd54;
      6'd60: return 6'd47;  6'd61: return 6'd55;  6'd62: return 6'd62;  default: return 6'd63;
    endcase
  endfunction

  assign in_ready  = !full[wr_bank];
  assign wr_fire   = in_valid && in_ready;
  assign wr_done   = wr_fire && (wcnt == 6'd63);

  assign out_valid = full[rd_bank];
  assign rd_fire   = out_valid && out_ready;
  assign rd_done   = rd_fire && (rcnt == 6'd63);

  assign out_data  = mem[{rd_bank, rcnt}];
  assign out_index = rcnt;
  assign out_last  = (rcnt == 6'd63);

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank, zz(wcnt)}] <= in_data;
    end
  end

  // A write can only complete an empty bank and a read can only drain a full
  // one, so when both finish on the same edge they touch different banks.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wcnt    <= 6'd0;
      rcnt    <= 6'd0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wcnt <= wcnt + 6'd1;
        if (wr_done) wr_bank <= !wr_bank;
      end
      if (rd_fire) begin
        rcnt <= rcnt + 6'd1;
        if (rd_done) rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_dezigzag_buffer.sv
module tb_dezigzag_buffer;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [5:0]    out_index;
  logic          out_last;

  dezigzag_buffer #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int zz_tab[64] = '{0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,
                     7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,
                     31,39,46,53,60,61,54,47,55,62,63};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a stream of expected raster-order outputs plus the block
  // currently being assembled from zigzag input.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] part[64];
  int            pcnt = 0;

  // Values sampled in the most recent cycle.
  logic          s_acc, s_xfer, s_valid, s_ready, s_last;
  logic [5:0]    s_idx;
  logic [DW-1:0] s_data;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [5:0]    prev_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    pcnt = 0;
    hold_prev = 1'b0;
  endtask

  // One clock cycle: drive after the falling edge, sample, compare with the
  // model, then advance the model by what the coming rising edge does.
  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy);
    int  sz;
    int  e_idx;
    logic e_ready, e_valid;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    sz      = exp_q.size();
    e_ready = (sz <= 64);
    e_valid = (sz > 0);
    e_idx   = (64 - (sz % 64)) % 64;
    check("in_ready", in_ready, e_ready);
    check("out_valid", out_valid, e_valid);
    check("out_index", out_index, e_idx);
    check("out_last", out_last, e_idx == 63);
    if (e_valid) check("out_data", out_data, exp_q[0]);
    if (hold_prev) begin
      check("hold_data", out_data, prev_data);
      check("hold_index", out_index, prev_idx);
    end
    s_valid = out_valid; s_ready = in_ready; s_last = out_last;
    s_idx = out_index;   s_data = out_data;
    s_acc  = iv && e_ready;
    s_xfer = e_valid && ordy;
    hold_prev = e_valid && !ordy;
    prev_data = out_data;
    prev_idx  = out_index;
    if (s_xfer) void'(exp_q.pop_front());
    if (s_acc) begin
      part[zz_tab[pcnt]] = d;
      pcnt++;
      if (pcnt == 64) begin
        for (int r = 0; r < 64; r++) exp_q.push_back(part[r]);
        pcnt = 0;
      end
    end
  endtask

  // Reset asserted between edges to exercise the asynchronous path.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0]    r;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t          vecs[12];
  logic [DW-1:0] cap[64];

  initial begin
    int nout, nlast, guard, acc, sent, started, gaps, drops, duty_i, duty_o;

    vecs[0]  = '{6'd0,  12'd0};
    vecs[1]  = '{6'd1,  12'd1};
    vecs[2]  = '{6'd8,  12'd2};
    vecs[3]  = '{6'd16, 12'd3};
    vecs[4]  = '{6'd9,  12'd4};
    vecs[5]  = '{6'd2,  12'd5};
    vecs[6]  = '{6'd4,  12'd14};
    vecs[7]  = '{6'd7,  12'd28};
    vecs[8]  = '{6'd56, 12'd35};
    vecs[9]  = '{6'd55, 12'd61};
    vecs[10] = '{6'd62, 12'd62};
    vecs[11] = '{6'd63, 12'd63};

    // Single block, in_data = k, raster reorder and one-cycle latency.
    do_reset();
    for (int k = 0; k < 64; k++) cyc(1'b1, DW'(k), 1'b1);
    nout = 0; nlast = 0; guard = 0;
    cyc(1'b0, '0, 1'b1);
    check("latency_valid", s_valid, 1);
    check("first_index", s_idx, 0);
    if (s_xfer) begin cap[s_idx] = s_data; nout++; end
    while (nout < 64 && guard < 200) begin
      cyc(1'b0, '0, 1'b1);
      if (s_xfer) begin
        cap[s_idx] = s_data;
        nout++;
        if (s_last) begin
          nlast++;
          check("last_index", s_idx, 63);
        end
      end
      guard++;
    end
    if (nout < 64) fail_timeout("single_block_drain");
    check("single_nlast", nlast, 1);
    for (int i = 0; i < 12; i++) check($sformatf("raster_r%0d", vecs[i].r), cap[vecs[i].r], vecs[i].exp_data);

    // Three blocks back to back, both handshakes held high.
    do_reset();
    sent = 0; nout = 0; started = 0; gaps = 0; drops = 0; guard = 0;
    while (nout < 192 && guard < 400) begin
      cyc(sent < 192, DW'($urandom), 1'b1);
      if (sent < 192 && !s_ready) drops++;
      if (s_acc) sent++;
      if (s_valid) started = 1;
      else if (started != 0) gaps++;
      if (s_xfer) nout++;
      guard++;
    end
    if (nout < 192) fail_timeout("b2b_drain");
    check("b2b_ready_drops", drops, 0);
    check("b2b_gaps", gaps, 0);

    // Both banks full, then drain.
    do_reset();
    acc = 0;
    for (int i = 0; i < 130; i++) begin
      cyc(1'b1, DW'($urandom), 1'b0);
      if (s_acc) acc++;
    end
    check("full_accepted", acc, 128);
    check("full_ready_low", s_ready, 0);
    guard = 0;
    do begin
      cyc(1'b0, '0, 1'b1);
      guard++;
    end while (!(s_xfer && s_last) && guard < 200);
    if (!(s_xfer && s_last)) fail_timeout("full_drain_block0");
    check("ready_low_at_r63", s_ready, 0);
    cyc(1'b0, '0, 1'b1);
    check("ready_back", s_ready, 1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin cyc(1'b0, '0, 1'b1); guard++; end
    if (exp_q.size() > 0) fail_timeout("full_drain_block1");

    // Random duty cycles on both sides, 50 blocks.
    do_reset();
    sent = 0; guard = 0;
    duty_i = $urandom_range(30, 70); duty_o = $urandom_range(30, 70);
    while ((sent < 3200 || exp_q.size() > 0) && guard < 40000) begin
      cyc(sent < 3200 && ($urandom_range(0, 99) < duty_i), DW'($urandom),
          $urandom_range(0, 99) < duty_o);
      if (s_acc) begin
        sent++;
        if (sent % 64 == 0) begin
          duty_i = $urandom_range(30, 70);
          duty_o = $urandom_range(30, 70);
        end
      end
      guard++;
    end
    if (sent < 3200 || exp_q.size() > 0) fail_timeout("random_stream");

    // Reset with one full block and a partial one; nothing may survive.
    do_reset();
    for (int i = 0; i < 104; i++) cyc(1'b1, DW'(i + 900), 1'b0);
    check("pre_reset_valid", s_valid, 1);
    do_reset();
    cyc(1'b0, '0, 1'b1);
    check("post_reset_ready", s_ready, 1);
    check("post_reset_valid", s_valid, 0);
    for (int k = 0; k < 64; k++) cyc(1'b1, DW'(k + 100), 1'b1);
    nout = 0; guard = 0;
    while (nout < 64 && guard < 200) begin
      cyc(1'b0, '0, 1'b1);
      if (s_xfer) nout++;
      guard++;
    end
    if (nout < 64) fail_timeout("post_reset_drain");
    cyc(1'b0, '0, 1'b1);
    check("post_reset_empty", s_valid, 0);

    // Block 1 completes on the same edge block 0 delivers r=63.
    do_reset();
    for (int k = 0; k < 64; k++) cyc(1'b1, DW'(k), 1'b0);
    for (int k = 0; k < 63; k++) cyc(1'b1, DW'(k + 500), 1'b0);
    for (int r = 0; r < 63; r++) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, DW'(563), 1'b1);
    check("same_edge_xfer_last", s_xfer && s_last, 1);
    check("same_edge_acc", s_acc, 1);
    cyc(1'b0, '0, 1'b0);
    check("same_edge_valid", s_valid, 1);
    check("same_edge_index", s_idx, 0);
    check("same_edge_data", s_data, 500);
    check("same_edge_ready", s_ready, 1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin cyc(1'b0, '0, 1'b1); guard++; end
    if (exp_q.size() > 0) fail_timeout("same_edge_drain");
    cyc(1'b0, '0, 1'b1);
    check("same_edge_empty", s_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
